// File: rtl/fetch_unit.sv
// fetch_unit: fetch stage between the PC prediction unit and instruction memory.
//
// Takes the predicted npc each cycle and issues it to instruction memory over a
// valid/ready request channel with at most one request outstanding. The fetched
// word goes back to the prediction unit (inst_feedback) and on to decode through
// a valid/ready handshake. A late branch squashes whatever is in flight or held.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   npc               predicted fetch address (valid every cycle)
//   br_late_done      late branch applied; npc is the redirect target
//   fetch_stall       high when npc was not consumed this cycle
//   inst_feedback     fetched word for early-branch target calculation
//   imem_req_*        request channel (valid/ready/addr)
//   imem_resp_*       response channel (valid/data)
//   dec_valid/ready   decode handshake; dec_inst/dec_pc carry the instruction
//   fetch_fault       sticky misaligned-fetch flag
module fetch_unit #(
  parameter bit FAULT_ON_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  input  logic        br_late_done,
  output logic        fetch_stall,
  output logic [31:0] inst_feedback,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StHold,
    StFault
  } state_e;

  state_e      r_state;
  state_e      w_state_d;
  logic        r_discard;
  logic        w_discard_d;
  logic [31:0] r_req_pc;
  logic [31:0] w_req_pc_d;
  logic [31:0] r_hold_inst;
  logic [31:0] w_hold_inst_d;
  logic [31:0] r_hold_pc;
  logic [31:0] w_hold_pc_d;
  logic        r_fault;
  logic        w_fault_d;

  logic w_misaligned;
  logic w_resp_take;
  logic w_drop;
  logic w_can_issue;
  logic w_issue;
  logic w_fault_now;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_discard   <= 1'b0;
      r_req_pc    <= 32'h0;
      r_hold_inst <= 32'h0;
      r_hold_pc   <= 32'h0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_discard   <= w_discard_d;
      r_req_pc    <= w_req_pc_d;
      r_hold_inst <= w_hold_inst_d;
      r_hold_pc   <= w_hold_pc_d;
      r_fault     <= w_fault_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d   = r_state;
    w_discard_d = r_discard;
    w_req_pc_d  = r_req_pc;
    w_fault_d   = r_fault;
    // Every taken response is captured, so inst_feedback keeps the last word seen
    // even after the instruction was consumed directly.
    w_hold_inst_d = w_resp_take ? imem_resp_data : r_hold_inst;
    w_hold_pc_d   = w_resp_take ? r_req_pc : r_hold_pc;

    if (w_fault_now) begin
      w_state_d = StFault;
      w_fault_d = 1'b1;
    end else if (w_issue) begin
      w_state_d   = StWait;
      w_discard_d = 1'b0;
      w_req_pc_d  = imem_req_addr;
      w_fault_d   = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: ;
        StWait: begin
          if (w_resp_take) begin
            w_state_d = (w_drop || dec_ready) ? StIdle : StHold;
          end else if (br_late_done) begin
            // Cannot reissue until the stale response drains; mark it for dropping.
            w_discard_d = 1'b1;
          end
        end
        StHold: begin
          if (dec_ready || br_late_done) w_state_d = StIdle;
        end
        StFault: begin
          if (br_late_done) begin
            w_state_d = StIdle;
            w_fault_d = 1'b0;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  // Output logic
  always_comb begin
    w_misaligned = FAULT_ON_MISALIGN && (npc[1:0] != 2'b00);
    w_resp_take  = (r_state == StWait) && imem_resp_valid;
    w_drop       = w_resp_take && (r_discard || br_late_done);

    w_can_issue = (r_state == StIdle) ||
                  ((r_state == StHold) && (dec_ready || br_late_done)) ||
                  (w_resp_take && (r_discard || br_late_done || dec_ready)) ||
                  ((r_state == StFault) && br_late_done);

    imem_req_valid = w_can_issue && !rst && !w_misaligned;
    imem_req_addr  = FAULT_ON_MISALIGN ? npc : {npc[31:2], 2'b00};
    w_issue        = imem_req_valid && imem_req_ready;
    fetch_stall    = !w_issue;
    w_fault_now    = w_can_issue && w_misaligned && !rst;

    dec_valid = !rst && !br_late_done &&
                ((w_resp_take && !r_discard) || (r_state == StHold));

    inst_feedback = w_resp_take ? imem_resp_data : r_hold_inst;
    dec_inst      = inst_feedback;
    dec_pc        = w_resp_take ? r_req_pc : r_hold_pc;
    fetch_fault   = r_fault;
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] npc = 32'h0;
  logic        br_late_done = 1'b0;
  logic        fetch_stall;
  logic [31:0] inst_feedback;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        fetch_fault;

  fetch_unit #(.FAULT_ON_MISALIGN(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .npc            (npc),
    .br_late_done   (br_late_done),
    .fetch_stall    (fetch_stall),
    .inst_feedback  (inst_feedback),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_inst       (dec_inst),
    .dec_pc         (dec_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } sb_t;
  sb_t exp_q[$];

  typedef struct {
    logic [31:0] npc;
    logic        rdy;
    logic        drdy;
    logic        exp_stall;
    logic        exp_rv;
    logic        exp_dv;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t vecs[$];

  // Memory model state
  int          mem_lat = 1;
  bit          mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2402_0005;
    if (a == 32'h20) return 32'h8C01_0010;
    return {a[15:0] ^ 16'h1357, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next cycle and present the memory response for it.
  task automatic tick();
    @(posedge clk);
    #1;
    imem_resp_valid = 1'b0;
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mem_addr);
      end
    end
  endtask

  // Sample away from the edge; run scoreboard and memory acceptance.
  task automatic settle();
    sb_t e;
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
    end else begin
      if (br_late_done) begin
        chk("dec_valid_during_br", {31'h0, dec_valid}, 32'h0);
        exp_q.delete();
      end
      if (dec_valid && dec_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected: got pc 0x%08h, expected no instruction", dec_pc);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", dec_pc, e.pc);
          chk("sb_inst", dec_inst, e.inst);
        end
      end
    end
    if (imem_resp_valid) mem_pend = 1'b0;
    if (imem_req_valid && imem_req_ready) begin
      mem_pend = 1'b1;
      mem_cnt  = mem_lat;
      mem_addr = imem_req_addr;
      e.pc     = imem_req_addr;
      e.inst   = mem_word(imem_req_addr);
      exp_q.push_back(e);
    end
  endtask

  task automatic cyc(input logic r, input logic [31:0] a, input logic br, input logic rdy,
                     input logic drdy);
    tick();
    rst            = r;
    npc            = a;
    br_late_done   = br;
    imem_req_ready = rdy;
    dec_ready      = drdy;
    settle();
  endtask

  initial begin
    // npc, req_ready, dec_ready, exp stall, exp req_valid, exp dec_valid, exp dec_pc
    vecs.push_back('{32'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00});
    vecs.push_back('{32'h04, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00});
    vecs.push_back('{32'h08, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h04});
    vecs.push_back('{32'h20, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h08});
    vecs.push_back('{32'h24, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h20});
    vecs.push_back('{32'h24, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h20});
    vecs.push_back('{32'h24, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h20});
    vecs.push_back('{32'h24, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h20});
    vecs.push_back('{32'h28, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h24});
    vecs.push_back('{32'h40, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h28});
    vecs.push_back('{32'h40, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00});
    vecs.push_back('{32'h40, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00});
    vecs.push_back('{32'h44, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40});
    vecs.push_back('{32'h44, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h44});

    // Reset state
    cyc(1'b1, 32'h0, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk("rst_dec_valid", {31'h0, dec_valid}, 32'h0);
    chk("rst_stall", {31'h0, fetch_stall}, 32'h1);
    chk("rst_fault", {31'h0, fetch_fault}, 32'h0);

    // Streaming, hold and request back-pressure, 1-cycle memory
    mem_lat = 1;
    foreach (vecs[i]) begin
      cyc(1'b0, vecs[i].npc, 1'b0, vecs[i].rdy, vecs[i].drdy);
      chk($sformatf("v%0d_stall", i), {31'h0, fetch_stall}, {31'h0, vecs[i].exp_stall});
      chk($sformatf("v%0d_req_valid", i), {31'h0, imem_req_valid}, {31'h0, vecs[i].exp_rv});
      chk($sformatf("v%0d_dec_valid", i), {31'h0, dec_valid}, {31'h0, vecs[i].exp_dv});
      if (vecs[i].exp_rv) chk($sformatf("v%0d_addr", i), imem_req_addr, vecs[i].npc);
      if (vecs[i].exp_dv) begin
        chk($sformatf("v%0d_dec_pc", i), dec_pc, vecs[i].exp_pc);
        chk($sformatf("v%0d_dec_inst", i), dec_inst, mem_word(vecs[i].exp_pc));
        chk($sformatf("v%0d_feedback", i), inst_feedback, mem_word(vecs[i].exp_pc));
      end
    end

    // Late branch while a 3-cycle fetch is outstanding
    mem_lat = 3;
    cyc(1'b0, 32'h10, 1'b0, 1'b1, 1'b1);
    chk("lb_issue_addr", imem_req_addr, 32'h10);
    cyc(1'b0, 32'h100, 1'b1, 1'b1, 1'b1);
    chk("lb_br_req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk("lb_br_stall", {31'h0, fetch_stall}, 32'h1);
    cyc(1'b0, 32'h100, 1'b0, 1'b1, 1'b1);
    chk("lb_wait_req_valid", {31'h0, imem_req_valid}, 32'h0);
    mem_lat = 1;
    cyc(1'b0, 32'h100, 1'b0, 1'b1, 1'b1);
    chk("lb_drop_dec_valid", {31'h0, dec_valid}, 32'h0);
    chk("lb_reissue_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("lb_reissue_addr", imem_req_addr, 32'h100);
    cyc(1'b0, 32'h104, 1'b0, 1'b0, 1'b1);
    chk("lb_dec_valid", {31'h0, dec_valid}, 32'h1);
    chk("lb_dec_pc", dec_pc, 32'h100);

    // Late branch flushes a held instruction
    cyc(1'b0, 32'h60, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 32'h64, 1'b0, 1'b0, 1'b0);
    chk("hb_dec_valid", {31'h0, dec_valid}, 32'h1);
    chk("hb_dec_pc", dec_pc, 32'h60);
    cyc(1'b0, 32'h80, 1'b1, 1'b1, 1'b0);
    chk("hb_flush_dec_valid", {31'h0, dec_valid}, 32'h0);
    chk("hb_issue_addr", imem_req_addr, 32'h80);
    chk("hb_issue_stall", {31'h0, fetch_stall}, 32'h0);
    cyc(1'b0, 32'h84, 1'b0, 1'b0, 1'b1);
    chk("hb_dec_pc2", dec_pc, 32'h80);

    // Misaligned fetch raises the sticky fault until a late branch
    cyc(1'b0, 32'h102, 1'b0, 1'b1, 1'b1);
    chk("mf_req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk("mf_stall", {31'h0, fetch_stall}, 32'h1);
    cyc(1'b0, 32'h102, 1'b0, 1'b1, 1'b1);
    chk("mf_fault", {31'h0, fetch_fault}, 32'h1);
    cyc(1'b0, 32'h104, 1'b0, 1'b1, 1'b1);
    chk("mf_hold_fault", {31'h0, fetch_fault}, 32'h1);
    chk("mf_hold_req_valid", {31'h0, imem_req_valid}, 32'h0);
    cyc(1'b0, 32'h200, 1'b1, 1'b1, 1'b1);
    chk("mf_br_req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("mf_br_addr", imem_req_addr, 32'h200);
    chk("mf_br_stall", {31'h0, fetch_stall}, 32'h0);
    cyc(1'b0, 32'h204, 1'b0, 1'b0, 1'b1);
    chk("mf_fault_clear", {31'h0, fetch_fault}, 32'h0);
    chk("mf_dec_pc", dec_pc, 32'h200);

    // Stale response after a mid-operation reset is ignored
    mem_lat = 2;
    cyc(1'b0, 32'h300, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 32'h300, 1'b0, 1'b1, 1'b1);
    chk("sr_rst_stall", {31'h0, fetch_stall}, 32'h1);
    cyc(1'b0, 32'h400, 1'b0, 1'b0, 1'b1);
    chk("sr_stale_dec_valid", {31'h0, dec_valid}, 32'h0);
    chk("sr_req_valid", {31'h0, imem_req_valid}, 32'h1);
    mem_lat = 1;
    cyc(1'b0, 32'h400, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 32'h404, 1'b0, 1'b0, 1'b1);
    chk("sr_dec_pc", dec_pc, 32'h400);

    chk("sb_drain", exp_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
